// File: rtl/icache_2way.sv
// ----------------------------------------------------------------------------
// icache_2way
//
// Read-only, 2-way set-associative instruction cache. It sits between the
// datapath fetch stage and the memory controller's instruction channel.
// A hit returns the word in the same cycle. A miss fetches the 2-word block
// one word at a time and commits it to the victim way. The datapath keeps
// re-presenting its request, so the first IDLE cycle after the fill returns
// the word as a hit.
//
// Ports:
//   CLK, nRST        clock; asynchronous active-low reset
//   imemREN/imemaddr datapath fetch request and byte address
//   ihit/imemload    word valid this cycle / instruction word
//   iREN/iaddr       fill request and word address to the controller
//   iwait/iload      controller busy flag / fill data (valid when iwait=0)
// ----------------------------------------------------------------------------
module icache_2way #(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 32 - IW - 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        FETCH1 = 2'd2
    } state_t;

    state_t          state_q, state_d;

    // Line storage; tag/data carry no reset because valid_q qualifies them.
    logic            valid_q [SETS][WAYS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][2];
    logic            lru_q   [SETS];

    // Block address of the outstanding miss (byte address bits [31:3]).
    logic [28:0]     miss_blk_q, miss_blk_d;
    logic [31:0]     buf0_q, buf0_d;

    logic [IW-1:0]   req_set_s;
    logic [TW-1:0]   req_tag_s;
    logic            req_off_s;
    logic [IW-1:0]   miss_set_s;
    logic [TW-1:0]   miss_tag_s;
    logic            match0_s, match1_s;
    logic            hit_s;
    logic            hit_way_s;
    logic            commit_s;
    logic            victim_s;
    logic            unused_s;

    assign req_set_s  = imemaddr[IW+2:3];
    assign req_tag_s  = imemaddr[31:IW+3];
    assign req_off_s  = imemaddr[2];
    assign miss_set_s = miss_blk_q[IW-1:0];
    assign miss_tag_s = miss_blk_q[28:IW];

    // Byte-within-word bits carry no information for word fetches.
    assign unused_s = ^imemaddr[1:0];

    // Tag compare of both ways; hits are only honoured while IDLE.
    always_comb begin
        match0_s  = valid_q[req_set_s][1'b0] && (tag_q[req_set_s][1'b0] == req_tag_s);
        match1_s  = valid_q[req_set_s][1'b1] && (tag_q[req_set_s][1'b1] == req_tag_s);
        hit_s     = (state_q == IDLE) && imemREN && (match0_s || match1_s);
        hit_way_s = match1_s;
        commit_s  = (state_q == FETCH1) && !iwait;
    end

    // Victim choice: fill an invalid way first, otherwise follow the LRU bit.
    always_comb begin
        if (!valid_q[miss_set_s][1'b0]) begin
            victim_s = 1'b0;
        end else if (!valid_q[miss_set_s][1'b1]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_q[miss_set_s];
        end
    end

    // Next-state logic for the miss-fill FSM.
    always_comb begin
        state_d    = state_q;
        miss_blk_d = miss_blk_q;
        buf0_d     = buf0_q;
        case (state_q)
            IDLE: begin
                if (imemREN && !hit_s) begin
                    miss_blk_d = imemaddr[31:3];
                    state_d    = FETCH0;
                end else begin
                    state_d    = IDLE;
                end
            end
            FETCH0: begin
                if (!iwait) begin
                    buf0_d  = iload;
                    state_d = FETCH1;
                end else begin
                    state_d = FETCH0;
                end
            end
            FETCH1: begin
                if (!iwait) begin
                    state_d = IDLE;
                end else begin
                    state_d = FETCH1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: hit data from the array, fill requests from the FSM.
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'd0;
        iREN     = 1'b0;
        iaddr    = 32'd0;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    ihit     = 1'b1;
                    imemload = data_q[req_set_s][hit_way_s][req_off_s];
                end else begin
                    ihit     = 1'b0;
                end
            end
            FETCH0: begin
                iREN  = 1'b1;
                iaddr = {miss_blk_q, 3'b000};
            end
            FETCH1: begin
                iREN  = 1'b1;
                iaddr = {miss_blk_q, 3'b100};
            end
            default: begin
                iREN  = 1'b0;
            end
        endcase
    end

    // State, valid, LRU and fill-buffer registers; reset aborts any fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            miss_blk_q <= 29'd0;
            buf0_q     <= 32'd0;
            for (int s = 0; s < SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q    <= state_d;
            miss_blk_q <= miss_blk_d;
            buf0_q     <= buf0_d;
            if (hit_s) begin
                lru_q[req_set_s] <= !hit_way_s;
            end else if (commit_s) begin
                lru_q[miss_set_s]             <= !victim_s;
                valid_q[miss_set_s][victim_s] <= 1'b1;
            end
        end
    end

    // Tag/data write of the completed block into the victim way.
    always_ff @(posedge CLK) begin
        if (commit_s) begin
            tag_q[miss_set_s][victim_s]        <= miss_tag_s;
            data_q[miss_set_s][victim_s][1'b0] <= buf0_q;
            data_q[miss_set_s][victim_s][1'b1] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_2way.sv
// ----------------------------------------------------------------------------
// tb_icache_2way
//
// Scoreboarded bench for icache_2way. The driver issues fetches, asks a
// recency-list model whether each should hit, and pushes the expected word
// and fill behaviour. A monitor checks every cycle: fill addresses, no hit
// during fills, idle outputs, and the word/latency on each ihit.
// ----------------------------------------------------------------------------
module tb_icache_2way;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks   = 0;
    int failures = 0;
    int wait_mode = 1;   // 0 random, 1 two waits per word, 2 long stall on word 1

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fill;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: per set, resident tags ordered LRU (index 0) to MRU.
    logic [25:0] rec [8][2];
    int          occ [8];

    icache_2way #(.SETS(8), .WAYS(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_0040) return 32'hAAAA_0001;
        else if (w == 32'h0000_0044) return 32'hAAAA_0002;
        else return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign iload = mem_word(iaddr);

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) occ[s] = 0;
    endfunction

    // Returns 1 on hit; updates recency order / inserts on miss.
    function automatic bit model_access(input logic [31:0] a);
        int s;
        logic [25:0] t;
        bit hit;
        s = int'(a[5:3]);
        t = a[31:6];
        hit = 1'b0;
        if (occ[s] >= 1 && rec[s][0] == t) begin
            hit = 1'b1;
            if (occ[s] == 2) begin
                rec[s][0] = rec[s][1];
                rec[s][1] = t;
            end
        end else if (occ[s] == 2 && rec[s][1] == t) begin
            hit = 1'b1;
        end else if (occ[s] < 2) begin
            rec[s][occ[s]] = t;
            occ[s] = occ[s] + 1;
        end else begin
            rec[s][0] = rec[s][1];
            rec[s][1] = t;
        end
        return hit;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_access(input logic [31:0] a);
        exp_t e;
        e.addr = a;
        e.data = mem_word(a);
        e.fill = !model_access(a);
        sb_q.push_back(e);
    endtask

    // Present a request until ihit (bounded), then release it.
    task automatic present(input logic [31:0] a);
        int n;
        bit got;
        imemREN  = 1'b1;
        imemaddr = a;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge CLK);
            got = ihit;
            @(posedge CLK);
            #1;
            n++;
        end
        chk("access_completes", {31'd0, got}, 32'd1);
        if (!got) sb_q.delete();
        imemREN = 1'b0;
    endtask

    task automatic access(input logic [31:0] a);
        expect_access(a);
        present(a);
    endtask

    task automatic idle_cycles(input int n);
        imemREN = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Controller model: produces iwait according to the active mode.
    initial begin : ctrl
        int cnt;
        cnt   = 0;
        iwait = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (!iREN) begin
                cnt   = 0;
                iwait = (wait_mode == 1);
            end else begin
                case (wait_mode)
                    0: iwait = ($urandom_range(0, 1) == 1);
                    1: begin
                        if (cnt < 2) begin iwait = 1'b1; cnt++; end
                        else begin iwait = 1'b0; cnt = 0; end
                    end
                    default: begin
                        if (iaddr[2] && cnt < 20) begin iwait = 1'b1; cnt++; end
                        else iwait = 1'b0;
                    end
                endcase
            end
        end
    end

    // Monitor: per-cycle protocol checks and scoreboard pop on each ihit.
    initial begin : monitor
        int   xfers;
        int   req_cycles;
        exp_t e;
        xfers = 0;
        req_cycles = 0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                xfers = 0;
                req_cycles = 0;
            end else begin
                if (imemREN) req_cycles++;
                if (iREN) begin
                    chk("no_hit_during_fill", {31'd0, ihit}, 32'd0);
                    if (sb_q.size() == 0) begin
                        chk("fill_without_request", {31'd0, iREN}, 32'd0);
                    end else begin
                        chk("fill_iaddr", iaddr, {sb_q[0].addr[31:3], xfers[0], 2'b00});
                    end
                    if (!iwait) xfers++;
                end else begin
                    chk("idle_iaddr", iaddr, 32'd0);
                    if (!imemREN) chk("idle_imemload", imemload, 32'd0);
                end
                if (!imemREN) chk("no_hit_without_ren", {31'd0, ihit}, 32'd0);
                if (ihit) begin
                    if (sb_q.size() == 0) begin
                        chk("hit_without_request", {31'd0, ihit}, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("hit_imemload", imemload, e.data);
                        chk("fill_word_count", xfers, e.fill ? 32'd2 : 32'd0);
                        if (!e.fill) chk("hit_same_cycle", req_cycles, 32'd1);
                    end
                    xfers = 0;
                    req_cycles = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : driver
        int n;
        logic [31:0] a;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        model_reset();
        #12;
        chk("reset_ihit", {31'd0, ihit}, 32'd0);
        chk("reset_imemload", imemload, 32'd0);
        chk("reset_iREN", {31'd0, iREN}, 32'd0);
        chk("reset_iaddr", iaddr, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle_cycles(2);

        // Cold miss, then the other word of the block hits.
        wait_mode = 1;
        access(32'h0000_0040);
        access(32'h0000_0044);

        // LRU eviction in set 0.
        access(32'h0000_0240);
        access(32'h0000_0040);
        access(32'h0000_0440);
        access(32'h0000_0040);
        access(32'h0000_0440);
        access(32'h0000_0240);

        // Redirect mid-fill: the fill still completes for 0x100.
        expect_access(32'h0000_0100);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        @(posedge CLK);
        #1;
        chk("redirect_in_fetch", {31'd0, iREN}, 32'd1);
        imemaddr = 32'h0000_0200;
        imemREN  = 1'b0;
        n = 0;
        while (iREN && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("redirect_fill_done", {31'd0, iREN}, 32'd0);
        present(32'h0000_0100);
        access(32'h0000_0200);

        // Reset during FETCH1: fill aborted, lines invalidated.
        expect_access(32'h0000_0900);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0900;
        n = 0;
        while (!(iREN && iaddr[2]) && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("reached_fetch1", {31'd0, iREN && iaddr[2]}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_reset_iREN", {31'd0, iREN}, 32'd0);
        chk("async_reset_iaddr", iaddr, 32'd0);
        sb_q.delete();
        model_reset();
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle_cycles(1);

        // 0x100 misses after reset; word 1 is stalled for 20 cycles.
        wait_mode = 2;
        access(32'h0000_0100);
        access(32'h0000_0104);

        // Idle period leaves LRU untouched: 0x018 is the victim.
        wait_mode = 1;
        access(32'h0000_0018);
        access(32'h0000_0218);
        access(32'h0000_0218);
        idle_cycles(10);
        access(32'h0000_0418);
        access(32'h0000_0218);
        access(32'h0000_0018);

        // Randomised traffic with random controller waits and idle gaps.
        wait_mode = 0;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 3)
                | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a = a | ($urandom & 32'hFFFF_F000);
            access(a);
            imemaddr = $urandom;
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
